// File: rtl/nand_arb_pkg.sv
// ============================================================================
//  nand_arb_pkg
//  Shared types and constants for the shared NAND datapath arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package nand_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam int                   OPS_CNT_W   = 16;
  localparam logic [OPS_CNT_W-1:0] OPS_CNT_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  rr_arbiter
//  Combinational round-robin grant search starting at ptr, wrapping modulo
//  NUM_REQ. The pointer register lives in the parent.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  import nand_arb_pkg::*;

  localparam logic [ID_W:0] C_NUM = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    w_sum   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // ptr is always < NUM_REQ, so one conditional subtract is enough to wrap
      w_sum = {1'b0, ptr} + (ID_W+1)'(off);
      if (w_sum >= C_NUM) begin
        w_sum = w_sum - C_NUM;
      end
      w_cand = w_sum[ID_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        gnt_idx = w_cand;
      end
    end
    any = |req;
    if (en && w_found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nand_share_arbiter.sv
// ============================================================================
//  nand_share_arbiter
//  Round-robin sharing of one registered bitwise-NAND stage among requesters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module nand_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [ID_W-1:0]          rsp_id,
  output logic [15:0]              ops_done
);

  import nand_arb_pkg::*;

  localparam logic [ID_W-1:0] C_LAST = ID_W'(NUM_REQ - 1);

  out_state_t             r_state;
  out_state_t             w_state_next;
  logic [ID_W-1:0]        r_ptr;
  logic [WIDTH-1:0]       r_y;
  logic [ID_W-1:0]        r_id;
  logic [OPS_CNT_W-1:0]   r_ops_done;

  logic                   w_accept;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [ID_W-1:0]        w_gnt_idx;
  logic                   w_any;
  logic                   w_fire;
  logic                   w_drain;
  logic [ID_W-1:0]        w_ptr_next;
  logic [WIDTH-1:0]       w_nand;
  logic [WIDTH-1:0]       w_a [NUM_REQ];
  logic [WIDTH-1:0]       w_b [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_a[g] = req_a[g*WIDTH +: WIDTH];
      assign w_b[g] = req_b[g*WIDTH +: WIDTH];
    end
  endgenerate

  // Gating with rst_n keeps req_ready low for the whole reset assertion
  assign w_accept = rst_n & ((r_state == EMPTY) | rsp_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_accept),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign req_ready  = w_gnt;
  assign w_fire     = w_accept & w_any;
  assign w_drain    = (r_state == FULL) & rsp_ready;
  assign w_ptr_next = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;
  assign w_nand     = ~(w_a[w_gnt_idx] & w_b[w_gnt_idx]);

  always_comb begin
    w_state_next = r_state;
    if (w_fire) begin
      w_state_next = FULL;
    end else if (w_drain) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_y        <= '0;
      r_id       <= '0;
      r_ops_done <= '0;
    end else begin
      if (w_fire) begin
        r_ptr <= w_ptr_next;
        r_y   <= w_nand;
        r_id  <= w_gnt_idx;
      end
      if (w_drain && (r_ops_done != OPS_CNT_MAX)) begin
        r_ops_done <= r_ops_done + 1'b1;
      end
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_y     = r_y;
  assign rsp_id    = r_id;
  assign ops_done  = r_ops_done;

endmodule

`default_nettype wire

// File: doc/nand_share_arbiter.md
Name: nand_share_arbiter

Overview:
- Shares one registered bitwise-NAND datapath between NUM_REQ requesters, each using a valid/ready handshake.
- Round-robin arbitration picks one request per cycle. The block computes y = ~(a & b) over WIDTH bits and holds it in a single output register with requester ID and backpressure.
- Sits between requesting logic blocks and downstream consumers. This is the shared-resource controller for the team's NAND gate datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (1..32).
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), requester ID width (derived, do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high (one-hot or zero).
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a.
- rsp_valid  out  1  result register holds valid data.
- rsp_ready  in  1  downstream accepts the result.
- rsp_y  out  WIDTH  NAND result.
- rsp_id  out  ID_W  index of the requester that produced rsp_y.
- ops_done  out  16  count of completed responses, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_y=0, rsp_id=0, ops_done=0, rr_ptr=0, state=EMPTY. req_ready=0 while reset is asserted.
- Output register state machine:
  - EMPTY: no valid result.
  - FULL: rsp_valid=1.
- accept = (state==EMPTY) | rsp_ready. This is a combinational path from rsp_ready to req_ready and is allowed.
- Grant: search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready[win] = accept & |req_valid.
  - All other req_ready bits = 0.
  - req_ready may depend combinationally on req_valid.
- Handshake (req_valid[i] & req_ready[i]) at edge t:
  - At t+1: rsp_y = ~(a_i & b_i), rsp_id = i, state=FULL, rr_ptr = (i+1) mod NUM_REQ.
  - Latency from request to rsp_valid is 1 cycle.
- No handshake: rr_ptr holds.
- Response handshake (rsp_valid & rsp_ready) with no simultaneous request: state -> EMPTY, rsp_y/rsp_id hold their last values.
- Simultaneous response drain and new request: state stays FULL and the register loads the new result. This gives full throughput of 1 op/cycle.
- FULL with rsp_ready=0: req_ready=0 and the register holds its contents stably.
- ops_done increments on each response handshake and saturates at 16'hFFFF, never wrapping.
- Requester rules:
  - Once asserted, req_valid/operands must stay stable until accepted.
  - The arbiter does not lock a grant while stalled. Re-arbitration occurs every cycle from the current rr_ptr.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,... with no requester waiting more than NUM_REQ-1 grants.
- Reset asserted mid-operation: any pending result is discarded and all state returns to reset values immediately. The first grant after reset goes to the lowest-index valid requester.

Decomposition:
- Shared package nand_arb_pkg holds:
  - typedef enum logic {EMPTY, FULL} out_state_t;
  - localparam OPS_CNT_W = 16;
  - localparam OPS_CNT_MAX = 16'hFFFF.
- One sub-module is natural: rr_arbiter.
  - Parameter: NUM_REQ.
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational. The parent owns the rr_ptr register.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> rsp_valid=0, req_ready=0, ops_done=0; release with no requests -> outputs unchanged.
- Single request: req_valid=4'b0010, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=4'b0010 same cycle; next cycle rsp_valid=1, rsp_y=8'hCF, rsp_id=1; ops_done=1 after drain.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3; one result every cycle.
- Backpressure: req_valid=4'b0001, rsp_ready=0 for 5 cycles -> first accept only, then req_ready=0; rsp_y/rsp_id stable; rsp_ready=1 -> drain and new accept in the same cycle.
- Pointer skip: rr_ptr=2, req_valid=4'b0011 -> grant requester 0, rr_ptr becomes 1; next request 4'b0011 -> grant requester 1.
- Reset mid-operation and counter saturation:
  - rst_n low while FULL -> rsp_valid drops at once (asynchronous).
  - Force ops_done to 16'hFFFE, complete 3 ops -> reads 16'hFFFF.
